seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle 32-bit shift unit that sits directly downstream of the fixed-distance shift stages (16/8/4/2/1).
- Consumes one stage per clock, in order 16, 8, 4, 2, 1, and registers the intermediate result between stages. This keeps the shift path off the ALU critical path.
- Started by single-cycle command pulses. Signals completion with a one-cycle ready pulse, in the same style as the multiplier/divider unit.

Parameters:
- WIDTH, 32, data width; must equal 2**SHAMT_W.
- SHAMT_W, 5, shift-amount width; also the stage count.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_SLL  input  1  one-cycle pulse: start logical left shift.
- ctrl_SRA  input  1  one-cycle pulse: start arithmetic right shift.
- data_operandA  input  WIDTH  operand; sampled only on a start edge.
- ctrl_shiftamt  input  SHAMT_W  shift distance; sampled only on a start edge.
- data_result  output  WIDTH  shifted value; held until the next start.
- data_resultRDY  output  1  one-cycle completion pulse.
- data_exception  output  1  one-cycle error pulse, coincident with data_resultRDY.
- busy  output  1  high while a shift is in progress.

Behaviour:
- Reset:
  - Sampled on the clock edge, active high; it is the only reset path.
  - data_result=0, data_resultRDY=0, data_exception=0, busy=0, FSM=IDLE, stage counter=0.
  - A reset asserted mid-operation abandons the operation; no RDY pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- Start (edge E0): ctrl_SLL xor ctrl_SRA high.
  - Latch operand into the working register, shift amount into the amount register, and direction.
  - Counter=0, busy=1, FSM=SHIFT.
  - Start is accepted in any state.
- Start while SHIFT: the current operation is aborted and restarted with the new inputs. No RDY is produced for the aborted operation.
- SHIFT (edges E1..E5): at edge Ek, the stage of distance 2**(SHAMT_W-k) is applied when amount bit [SHAMT_W-k] is 1; otherwise the working register passes through unchanged.
  - SLL fills vacated bits with 0.
  - SRA fills vacated bits with working-register bit [WIDTH-1]. That bit equals the original sign bit, which is preserved.
- Completion at E5:
  - data_result <= final working value; data_resultRDY=1; busy=0; FSM=DONE.
  - Start-to-RDY latency is 5 cycles, for every shift amount including 0.
- DONE: lasts one cycle, then IDLE. data_resultRDY drops after that cycle. data_result stays held.
- Amount 0: result equals the operand; latency is still 5 cycles.
- Simultaneous ctrl_SLL and ctrl_SRA:
  - The operation is invalid and no shift is started.
  - On the next edge: data_exception=1, data_resultRDY=1, data_result=0, for one cycle; FSM=DONE.
  - Any in-flight operation is aborted.
- data_operandA and ctrl_shiftamt are ignored in every cycle except a start edge.
- busy is 0 in IDLE and DONE, and 1 in SHIFT.

Optional Feature:
- Macro: SEQ_SHIFTER_EARLY_EXIT_EN.
- Defined:
  - SHIFT terminates after the stage corresponding to the lowest set bit of the latched amount.
  - Latency = 5 - (index of the lowest set amount bit). Examples: amount 16 gives 1 cycle; amount 1, 3 or 31 gives 5 cycles.
  - Amount 0 completes at E1 with data_result = operand.
  - All other rules are unchanged (abort, exception, reset, hold).
- Undefined: fixed 5-cycle latency as specified above.

Test Plan:
- SLL, data_operandA=0x0000FFFF, ctrl_shiftamt=16 -> data_resultRDY pulse exactly 5 cycles after start; data_result=0xFFFF0000; busy high for cycles 1-5.
- SRA, 0x80000000 by 4 -> 0xF8000000. SRA, 0x7FFFFFFF by 31 -> 0x00000000. SLL, 0x00000001 by 31 -> 0x80000000.
- ctrl_SLL and ctrl_SRA both high -> next cycle data_exception=1, data_resultRDY=1, data_result=0, all for one cycle only.
- Abort: SLL 0x1 by 3, then at cycle 2 start SRA 0xF0000000 by 8 -> exactly one RDY pulse, 5 cycles after the second start; data_result=0xFFF00000.
- Reset at cycle 3 of SLL 0x1234 by 1 -> all outputs 0 on the next edge; no RDY over the following 10 cycles; a later SLL 0x1234 by 1 -> 0x2468.
- With SEQ_SHIFTER_EARLY_EXIT_EN: SLL 0xAB by 16 -> RDY 1 cycle after start, result 0x00AB0000; amount 0 -> RDY 1 cycle after start, result equals operand. Without the macro, both take 5 cycles.

Source files
------------

// File: rtl/seq_shifter_if.sv
// seq_shifter_if -- command/result bundle for the multi-cycle shift unit.
//   master : drives ctrl_SLL, ctrl_SRA, data_operandA, ctrl_shiftamt;
//            receives data_result, data_resultRDY, data_exception, busy
//   slave  : the shifter side (mirror of master)
interface seq_shifter_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               ctrl_SLL;
   logic               ctrl_SRA;
   logic [WIDTH-1:0]   data_operandA;
   logic [SHAMT_W-1:0] ctrl_shiftamt;
   logic [WIDTH-1:0]   data_result;
   logic               data_resultRDY;
   logic               data_exception;
   logic               busy;

   modport master (
      output ctrl_SLL, ctrl_SRA, data_operandA, ctrl_shiftamt,
      input  data_result, data_resultRDY, data_exception, busy
   );

   modport slave (
      input  ctrl_SLL, ctrl_SRA, data_operandA, ctrl_shiftamt,
      output data_result, data_resultRDY, data_exception, busy
   );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter -- multi-cycle WIDTH-bit shifter (SLL / SRA), one fixed-distance
// stage per clock in order 2**(SHAMT_W-1) .. 1, intermediate value registered.
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : seq_shifter_if.slave (start pulses, operand, amount, result,
//            one-cycle ready / exception pulses, busy)
// Build option: define SEQ_SHIFTER_EARLY_EXIT_EN to end the shift right after
// the stage of the lowest set amount bit (amount 0 finishes after one stage).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; result held
// SHIFT | applying one stage per clock, counter selects the stage
// DONE  | one-cycle ready (and possibly exception) pulse, then IDLE
module seq_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic        clock,
   input  logic        reset,
   seq_shifter_if.slave bus
);
   localparam int CNT_W = $clog2(SHAMT_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   result;
   logic [SHAMT_W-1:0] amt;
   logic               dir_sra;
   logic [CNT_W-1:0]   cnt;
   logic               rdy;
   logic               exc;
   logic               busy_q;

   logic               start;
   logic               invalid;
   logic [WIDTH-1:0]   stage_out;
   logic               last_stage;

   assign start   = bus.ctrl_SLL ^ bus.ctrl_SRA;
   assign invalid = bus.ctrl_SLL & bus.ctrl_SRA;

   // Stage cnt applies distance 2**(SHAMT_W-1-cnt) when that amount bit is set.
   // Each branch is a constant-distance shift, so this is a mux, not a barrel.
   always_comb begin
      stage_out = work;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (cnt == CNT_W'(i) && amt[SHAMT_W-1-i]) begin
            if (dir_sra)
               stage_out = $signed(work) >>> (2 ** (SHAMT_W - 1 - i));
            else
               stage_out = work << (2 ** (SHAMT_W - 1 - i));
         end
      end
   end

`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
   // Finish once no lower amount bits remain to be applied.
   always_comb begin
      last_stage = 1'b0;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (cnt == CNT_W'(i))
            last_stage = ((amt & SHAMT_W'((1 << (SHAMT_W - 1 - i)) - 1)) == '0);
      end
   end
`else
   always_comb begin
      last_stage = (cnt == CNT_W'(SHAMT_W - 1));
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         work    <= '0;
         result  <= '0;
         amt     <= '0;
         dir_sra <= 1'b0;
         cnt     <= '0;
         rdy     <= 1'b0;
         exc     <= 1'b0;
         busy_q  <= 1'b0;
      end else if (invalid) begin
         // both directions requested: abort anything in flight, flag error
         state  <= DONE;
         result <= '0;
         cnt    <= '0;
         rdy    <= 1'b1;
         exc    <= 1'b1;
         busy_q <= 1'b0;
      end else if (start) begin
         state   <= SHIFT;
         work    <= bus.data_operandA;
         amt     <= bus.ctrl_shiftamt;
         dir_sra <= bus.ctrl_SRA;
         cnt     <= '0;
         rdy     <= 1'b0;
         exc     <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         case (state)
            SHIFT: begin
               work <= stage_out;
               if (last_stage) begin
                  state  <= DONE;
                  result <= stage_out;
                  cnt    <= '0;
                  rdy    <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               rdy   <= 1'b0;
               exc   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               rdy   <= 1'b0;
               exc   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_result    = result;
   assign bus.data_resultRDY = rdy;
   assign bus.data_exception = exc;
   assign bus.busy           = busy_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter -- self-checking bench for seq_shifter. Expected results come
// from plain shift arithmetic; expected latency from the amount's lowest set bit
// when SEQ_SHIFTER_EARLY_EXIT_EN is defined, otherwise a fixed 5 cycles.
module tb_seq_shifter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

   seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] exp_result(input bit sra, input logic [31:0] op,
                                              input logic [4:0] amt);
      if (sra) return $signed(op) >>> amt;
      return op << amt;
   endfunction

   function automatic int exp_lat(input logic [4:0] amt);
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
      if (amt == 0) return 1;
      for (int j = 0; j < 5; j++)
         if (amt[j]) return 5 - j;
      return 5;
`else
      return 5;
`endif
   endfunction

   // Starts one operation and measures it: lat = edges after the start edge
   // until RDY is seen (-1 on timeout). Inputs are scrambled after the start
   // edge since they must be ignored.
   task automatic do_op(input bit sra, input logic [31:0] op, input logic [4:0] amt,
                        output int lat, output logic [31:0] res, output bit busy_ok,
                        output bit pulse_ok, output logic exc);
      busy_ok  = 1'b1;
      pulse_ok = 1'b1;
      lat      = -1;
      res      = '0;
      exc      = 1'b0;
      @(negedge clock);
      bus.ctrl_SLL      = !sra;
      bus.ctrl_SRA      = sra;
      bus.data_operandA = op;
      bus.ctrl_shiftamt = amt;
      @(negedge clock);
      bus.ctrl_SLL      = 1'b0;
      bus.ctrl_SRA      = 1'b0;
      bus.data_operandA = $urandom;
      bus.ctrl_shiftamt = 5'($urandom);
      for (int c = 0; c < 20; c++) begin
         if (bus.data_resultRDY) begin
            lat = c;
            res = bus.data_result;
            exc = bus.data_exception;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
         @(negedge clock);
      end
      if (lat >= 0) begin
         @(negedge clock);
         if (bus.data_resultRDY || bus.data_result !== res) pulse_ok = 1'b0;
      end
   endtask

   task automatic check_op(input string name, input bit sra, input logic [31:0] op,
                           input logic [4:0] amt, input logic [31:0] want,
                           input int want_lat);
      int lat; logic [31:0] res; bit bok, pok; logic exc;
      do_op(sra, op, amt, lat, res, bok, pok, exc);
      total++;
      if (lat !== want_lat) begin
         bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, want_lat);
      end
      total++;
      if (res !== want) begin
         bad++; $display("FAIL %s result got=%h exp=%h", name, res, want);
      end
      total++;
      if (bok !== 1'b1 || pok !== 1'b1 || exc !== 1'b0) begin
         bad++; $display("FAIL %s busy/pulse/exc got=%0b%0b%0b exp=110", name, bok, pok, exc);
      end
   endtask

   task automatic test_reset();
      bus.ctrl_SLL = 0; bus.ctrl_SRA = 0; bus.data_operandA = '0; bus.ctrl_shiftamt = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      total++;
      if ({bus.data_result, bus.data_resultRDY, bus.data_exception, bus.busy} !== 35'd0) begin
         bad++; $display("FAIL reset_state got=%h/%b%b%b exp=0/000", bus.data_result,
                         bus.data_resultRDY, bus.data_exception, bus.busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      check_op("sll_ffff_16", 1'b0, 32'h0000FFFF, 5'd16, 32'hFFFF0000, exp_lat(5'd16));
      check_op("sra_8000_4",  1'b1, 32'h80000000, 5'd4,  32'hF8000000, exp_lat(5'd4));
      check_op("sra_7fff_31", 1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000, 5);
      check_op("sll_1_31",    1'b0, 32'h00000001, 5'd31, 32'h80000000, 5);
      check_op("sra_neg_31",  1'b1, 32'h80000001, 5'd31, 32'hFFFFFFFF, 5);
   endtask

   task automatic test_early_exit();
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
      check_op("early_sll_ab_16", 1'b0, 32'h000000AB, 5'd16, 32'h00AB0000, 1);
      check_op("early_amt0",      1'b1, 32'h9ABCDEF0, 5'd0,  32'h9ABCDEF0, 1);
`else
      check_op("fixed_sll_ab_16", 1'b0, 32'h000000AB, 5'd16, 32'h00AB0000, 5);
      check_op("fixed_amt0",      1'b1, 32'h9ABCDEF0, 5'd0,  32'h9ABCDEF0, 5);
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         bit sra = 1'($urandom);
         logic [31:0] op = $urandom;
         logic [4:0] amt = 5'($urandom);
         check_op($sformatf("rand_%0d", n), sra, op, amt, exp_result(sra, op, amt),
                  exp_lat(amt));
      end
   endtask

   task automatic test_exception();
      int rdy_seen = 0;
      @(negedge clock);
      bus.ctrl_SLL = 1; bus.data_operandA = 32'h0000F00D; bus.ctrl_shiftamt = 5'd1;
      @(negedge clock);
      bus.ctrl_SLL = 0;
      @(negedge clock);
      bus.ctrl_SLL = 1; bus.ctrl_SRA = 1;
      @(negedge clock);
      bus.ctrl_SLL = 0; bus.ctrl_SRA = 0;
      total++;
      if ({bus.data_resultRDY, bus.data_exception, bus.busy} !== 3'b110 || bus.data_result !== 0) begin
         bad++; $display("FAIL exc_pulse got=%b%b%b/%h exp=110/0", bus.data_resultRDY,
                         bus.data_exception, bus.busy, bus.data_result);
      end
      @(negedge clock);
      total++;
      if ({bus.data_resultRDY, bus.data_exception} !== 2'b00 || bus.data_result !== 0) begin
         bad++; $display("FAIL exc_one_cycle got=%b%b/%h exp=00/0", bus.data_resultRDY,
                         bus.data_exception, bus.data_result);
      end
      repeat (8) begin
         @(negedge clock);
         if (bus.data_resultRDY) rdy_seen++;
      end
      total++;
      if (rdy_seen != 0) begin
         bad++; $display("FAIL exc_abort_inflight got=%0d rdy exp=0", rdy_seen);
      end
   endtask

   task automatic test_abort();
      int rdy_seen = 0;
      int first = -1;
      logic [31:0] res = '0;
      @(negedge clock);
      bus.ctrl_SLL = 1; bus.data_operandA = 32'h1; bus.ctrl_shiftamt = 5'd3;
      @(negedge clock);
      bus.ctrl_SLL = 0;
      @(negedge clock);
      bus.ctrl_SRA = 1; bus.data_operandA = 32'hF0000000; bus.ctrl_shiftamt = 5'd8;
      @(negedge clock);
      bus.ctrl_SRA = 0; bus.data_operandA = $urandom; bus.ctrl_shiftamt = 5'($urandom);
      for (int c = 0; c < 12; c++) begin
         if (bus.data_resultRDY) begin
            rdy_seen++;
            if (first < 0) begin first = c; res = bus.data_result; end
         end
         @(negedge clock);
      end
      total++;
      if (rdy_seen != 1 || first != exp_lat(5'd8)) begin
         bad++; $display("FAIL abort_rdy got=%0d pulses at %0d exp=1 at %0d", rdy_seen, first,
                         exp_lat(5'd8));
      end
      total++;
      if (res !== 32'hFFF00000) begin
         bad++; $display("FAIL abort_result got=%h exp=fff00000", res);
      end
   endtask

   task automatic test_reset_mid();
      int rdy_seen = 0;
      @(negedge clock);
      bus.ctrl_SLL = 1; bus.data_operandA = 32'h1234; bus.ctrl_shiftamt = 5'd1;
      @(negedge clock);
      bus.ctrl_SLL = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      total++;
      if ({bus.data_result, bus.data_resultRDY, bus.data_exception, bus.busy} !== 35'd0) begin
         bad++; $display("FAIL reset_mid got=%h/%b%b%b exp=0/000", bus.data_result,
                         bus.data_resultRDY, bus.data_exception, bus.busy);
      end
      repeat (10) begin
         @(negedge clock);
         if (bus.data_resultRDY) rdy_seen++;
      end
      total++;
      if (rdy_seen != 0) begin
         bad++; $display("FAIL reset_no_rdy got=%0d exp=0", rdy_seen);
      end
      check_op("after_reset_sll", 1'b0, 32'h1234, 5'd1, 32'h2468, 5);
   endtask

   task automatic test_back_to_back();
      int lat = -1;
      logic [31:0] op = $urandom;
      logic [4:0] amt = 5'($urandom);
      bit timeout = 1'b1;
      @(negedge clock);
      bus.ctrl_SRA = 1; bus.data_operandA = 32'hDEADBEEF; bus.ctrl_shiftamt = 5'd12;
      @(negedge clock);
      bus.ctrl_SRA = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.data_resultRDY) begin timeout = 1'b0; break; end
         @(negedge clock);
      end
      total++;
      if (timeout || bus.data_result !== 32'hFFFDEADB) begin
         bad++; $display("FAIL b2b_first got=%h timeout=%0b exp=fffdeadb", bus.data_result, timeout);
      end
      // next start issued in the DONE cycle
      bus.ctrl_SLL = 1; bus.data_operandA = op; bus.ctrl_shiftamt = amt;
      @(negedge clock);
      bus.ctrl_SLL = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.data_resultRDY) begin lat = c; break; end
         @(negedge clock);
      end
      total++;
      if (lat != exp_lat(amt) || bus.data_result !== exp_result(1'b0, op, amt)) begin
         bad++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=%0d", bus.data_result, lat,
                         exp_result(1'b0, op, amt), exp_lat(amt));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_early_exit();
      test_exception();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
